// File: rtl/system_0_sysid_pkg.sv
// -----------------------------------------------------------------------------
// system_0_sysid_pkg
// Shared definitions for the boot-time system ID checker:
//   - state_t           : checker FSM states
//   - SYSID_ADDR_*      : word select values on the system ID slave control port
//   - DEFAULT_EXPECTED_*: expected ID / build timestamp, also consumed by the
//                         software header generator so both sides agree
//   - wait_load()       : converts a cycle count into a down-counter load value
// -----------------------------------------------------------------------------
package system_0_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_ID = 3'd1,
    ST_RD_TS = 3'd2,
    ST_CHECK = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h6942_0C5F;  // 1765936223

  localparam int unsigned WAIT_CNT_W = 8;

  // A phase lasting N cycles loads N-1: the counter reports done during the
  // cycle in which it holds zero, i.e. the last cycle of the phase.
  function automatic logic [WAIT_CNT_W-1:0] wait_load(input int unsigned cycles);
    return WAIT_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/system_0_sysid_wait_cnt.sv
// -----------------------------------------------------------------------------
// system_0_sysid_wait_cnt
// Loadable down-counter used by the checker to time both the read strobe
// length and the idle gap between retry passes.
// Ports:
//   i_clock      in   system clock
//   i_reset_n    in   synchronous active-low reset (count -> 0)
//   i_load       in   load i_load_value this cycle (has priority over counting)
//   i_load_value in   W  value to load
//   o_done       out  count has reached zero (stays done until reloaded)
// -----------------------------------------------------------------------------
module system_0_sysid_wait_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_value,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/system_0_sysid_checker.sv
// -----------------------------------------------------------------------------
// system_0_sysid_checker
// Boot-time Avalon-MM read master for the system ID slave. Reads word 0
// (system ID) and word 1 (build timestamp), compares both against the expected
// values, retries whole passes on mismatch, and reports the result. o_system_ok
// gates software release and stays low until both words match.
// Ports:
//   i_clock            in   system clock
//   i_reset_n          in   synchronous active-low reset
//   i_recheck          in   1-cycle pulse, restarts the check from DONE only
//   o_sysid_address    out  slave word select (0 = ID, 1 = timestamp)
//   o_sysid_read       out  read strobe
//   i_sysid_readdata   in   32  slave read data
//   o_busy             out  sequence in progress
//   o_check_done       out  sequence finished (sticky until recheck/reset)
//   o_system_ok        out  both words matched on the last pass
//   o_id_match         out  ID word matched on the last pass
//   o_ts_match         out  timestamp word matched on the last pass
//   o_captured_id      out  32  last ID word sampled
//   o_captured_ts      out  32  last timestamp word sampled
//   o_retry_count      out  4   passes retried in the current sequence
// All outputs come straight from flops; read data only reaches the outputs
// through the capture registers.
// -----------------------------------------------------------------------------
module system_0_sysid_checker
  import system_0_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS  = DEFAULT_EXPECTED_TS,
  parameter int unsigned READ_LATENCY = 1,   // 1..7
  parameter int unsigned MAX_RETRIES  = 3,   // 0..15
  parameter int unsigned RETRY_GAP    = 16   // 1..255
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_recheck,
  output logic        o_sysid_address,
  output logic        o_sysid_read,
  input  logic [31:0] i_sysid_readdata,
  output logic        o_busy,
  output logic        o_check_done,
  output logic        o_system_ok,
  output logic        o_id_match,
  output logic        o_ts_match,
  output logic [31:0] o_captured_id,
  output logic [31:0] o_captured_ts,
  output logic [3:0]  o_retry_count
);

  localparam logic [WAIT_CNT_W-1:0] LOAD_READ   = wait_load(READ_LATENCY);
  localparam logic [WAIT_CNT_W-1:0] LOAD_GAP    = wait_load(RETRY_GAP);
  localparam logic [3:0]            MAX_RETRY_L = 4'(MAX_RETRIES);

  state_t      r_state;
  logic        r_sysid_address;
  logic        r_sysid_read;
  logic        r_busy;
  logic        r_check_done;
  logic        r_system_ok;
  logic        r_id_match;
  logic        r_ts_match;
  logic [31:0] r_captured_id;
  logic [31:0] r_captured_ts;
  logic [3:0]  r_retry_count;

  state_t      w_state_next;
  logic        w_sysid_address_next;
  logic        w_sysid_read_next;
  logic        w_busy_next;
  logic        w_check_done_next;
  logic        w_system_ok_next;
  logic        w_id_match_next;
  logic        w_ts_match_next;
  logic [31:0] w_captured_id_next;
  logic [31:0] w_captured_ts_next;
  logic [3:0]  w_retry_count_next;

  logic                  w_cnt_load;
  logic [WAIT_CNT_W-1:0] w_cnt_load_value;
  logic                  w_cnt_done;
  logic                  w_id_eq;
  logic                  w_ts_eq;

  system_0_sysid_wait_cnt #(
    .W (WAIT_CNT_W)
  ) u_wait_cnt (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_load       (w_cnt_load),
    .i_load_value (w_cnt_load_value),
    .o_done       (w_cnt_done)
  );

  // Compare against the capture registers, never against live read data.
  assign w_id_eq = (r_captured_id == EXPECTED_ID);
  assign w_ts_eq = (r_captured_ts == EXPECTED_TS);

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state         <= ST_RD_ID;
      r_sysid_address <= SYSID_ADDR_ID;
      r_sysid_read    <= 1'b0;
      r_busy          <= 1'b0;
      r_check_done    <= 1'b0;
      r_system_ok     <= 1'b0;
      r_id_match      <= 1'b0;
      r_ts_match      <= 1'b0;
      r_captured_id   <= '0;
      r_captured_ts   <= '0;
      r_retry_count   <= '0;
    end else begin
      r_state         <= w_state_next;
      r_sysid_address <= w_sysid_address_next;
      r_sysid_read    <= w_sysid_read_next;
      r_busy          <= w_busy_next;
      r_check_done    <= w_check_done_next;
      r_system_ok     <= w_system_ok_next;
      r_id_match      <= w_id_match_next;
      r_ts_match      <= w_ts_match_next;
      r_captured_id   <= w_captured_id_next;
      r_captured_ts   <= w_captured_ts_next;
      r_retry_count   <= w_retry_count_next;
    end
  end

  always_comb begin
    w_state_next         = r_state;
    w_sysid_address_next = r_sysid_address;
    w_sysid_read_next    = r_sysid_read;
    w_check_done_next    = r_check_done;
    w_system_ok_next     = r_system_ok;
    w_id_match_next      = r_id_match;
    w_ts_match_next      = r_ts_match;
    w_captured_id_next   = r_captured_id;
    w_captured_ts_next   = r_captured_ts;
    w_retry_count_next   = r_retry_count;
    w_cnt_load           = 1'b0;
    w_cnt_load_value     = LOAD_READ;

    case (r_state)
      ST_IDLE: begin
        w_state_next         = ST_RD_ID;
        w_sysid_address_next = SYSID_ADDR_ID;
        w_sysid_read_next    = 1'b1;
        w_cnt_load           = 1'b1;
      end

      ST_RD_ID: begin
        if (!r_sysid_read) begin
          // Reset leaves us in RD_ID with the strobe low: launch the read.
          w_sysid_address_next = SYSID_ADDR_ID;
          w_sysid_read_next    = 1'b1;
          w_cnt_load           = 1'b1;
        end else if (w_cnt_done) begin
          // Last read cycle of the ID word: sample, then switch the address
          // at the state boundary and keep the strobe up for the timestamp.
          w_captured_id_next   = i_sysid_readdata;
          w_state_next         = ST_RD_TS;
          w_sysid_address_next = SYSID_ADDR_TS;
          w_cnt_load           = 1'b1;
        end
      end

      ST_RD_TS: begin
        if (w_cnt_done) begin
          w_captured_ts_next = i_sysid_readdata;
          w_sysid_read_next  = 1'b0;
          w_state_next       = ST_CHECK;
        end
      end

      ST_CHECK: begin
        w_id_match_next = w_id_eq;
        w_ts_match_next = w_ts_eq;
        if (w_id_eq && w_ts_eq) begin
          w_system_ok_next  = 1'b1;
          w_check_done_next = 1'b1;
          w_state_next      = ST_DONE;
        end else if (r_retry_count < MAX_RETRY_L) begin
          w_retry_count_next = r_retry_count + 4'd1;
          w_state_next       = ST_GAP;
          w_cnt_load         = 1'b1;
          w_cnt_load_value   = LOAD_GAP;
        end else begin
          w_system_ok_next  = 1'b0;
          w_check_done_next = 1'b1;
          w_state_next      = ST_DONE;
        end
      end

      ST_GAP: begin
        if (w_cnt_done) begin
          w_state_next         = ST_RD_ID;
          w_sysid_address_next = SYSID_ADDR_ID;
          w_sysid_read_next    = 1'b1;
          w_cnt_load           = 1'b1;
        end
      end

      ST_DONE: begin
        // Captured words are deliberately kept across a recheck.
        if (i_recheck) begin
          w_check_done_next    = 1'b0;
          w_system_ok_next     = 1'b0;
          w_id_match_next      = 1'b0;
          w_ts_match_next      = 1'b0;
          w_retry_count_next   = '0;
          w_state_next         = ST_RD_ID;
          w_sysid_address_next = SYSID_ADDR_ID;
          w_sysid_read_next    = 1'b1;
          w_cnt_load           = 1'b1;
        end
      end

      default: begin
        w_state_next      = ST_RD_ID;
        w_sysid_read_next = 1'b0;
      end
    endcase

    w_busy_next = (w_state_next != ST_DONE);
  end

  assign o_sysid_address = r_sysid_address;
  assign o_sysid_read    = r_sysid_read;
  assign o_busy          = r_busy;
  assign o_check_done    = r_check_done;
  assign o_system_ok     = r_system_ok;
  assign o_id_match      = r_id_match;
  assign o_ts_match      = r_ts_match;
  assign o_captured_id   = r_captured_id;
  assign o_captured_ts   = r_captured_ts;
  assign o_retry_count   = r_retry_count;

endmodule
